// File: rtl/highpass_sequencer_pkg.sv
// Shared definitions for the highpass filter frame sequencer.
package hp_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PROCESS,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int unsigned DEF_NUM_PIXELS     = 65536;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1048576;

endpackage

// File: rtl/highpass_sequencer_counter.sv
// Loadable up-counter with synchronous clear, enable and terminal compare.
module hp_seq_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_count,
    output logic         o_at_term
);

    logic [W-1:0] r_count;

    // Count register: clear beats load, load beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_at_term = (r_count == i_term);

endmodule

// File: rtl/highpass_sequencer.sv
// Frame sequencer: loads NUM_PIXELS pixels into the highpass filter, then
// runs its process phase and forwards filter output until finish/timeout.
module highpass_sequencer
    import hp_seq_pkg::*;
#(
    parameter int unsigned NUM_PIXELS     = DEF_NUM_PIXELS,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [7:0]       filt_image_input,
    output logic             filt_enable,
    output logic             filt_enable_process,
    input  logic [7:0]       filt_image_output,
    input  logic             filt_finish,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] pix_in_count,
    output logic [CNT_W-1:0] pix_out_count
);

    localparam logic [CNT_W-1:0] LP_IN_TERM  = CNT_W'(NUM_PIXELS - 1);
    localparam logic [CNT_W-1:0] LP_TMO_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    logic       r_filt_enable;
    logic       r_fep;
    logic       r_out_valid;
    logic       r_done;
    logic       r_error;
    logic [7:0] r_img_in;
    logic [7:0] r_out_data;

    logic             w_idle_like;
    logic             w_start_go;
    logic             w_hs;
    logic             w_proc_act;
    logic             w_fwd;
    logic             w_in_term;
    logic             w_tmo_term;
    logic             w_out_sat;
    logic [CNT_W-1:0] w_tmo_count;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
    assign w_start_go  = start & ~abort & w_idle_like;
    assign w_hs        = in_valid & (r_state == ST_LOAD) & ~abort;
    // The first PROCESS cycle only raises enable_process; the filter is
    // considered processing (finish, forwarding, timeout) once it is high.
    assign w_proc_act  = (r_state == ST_PROCESS) & r_fep & ~abort;
    assign w_fwd       = w_proc_act & ~filt_finish & ~w_tmo_term;

    hp_seq_counter #(.W(CNT_W)) u_cnt_in (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_start_go),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_hs),
        .i_term     (LP_IN_TERM),
        .o_count    (pix_in_count),
        .o_at_term  (w_in_term)
    );

    // Output count saturates at all-ones rather than wrapping.
    hp_seq_counter #(.W(CNT_W)) u_cnt_out (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_start_go),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_fwd & ~w_out_sat),
        .i_term     ('1),
        .o_count    (pix_out_count),
        .o_at_term  (w_out_sat)
    );

    hp_seq_counter #(.W(CNT_W)) u_cnt_tmo (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_start_go),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_proc_act),
        .i_term     (LP_TMO_TERM),
        .o_count    (w_tmo_count),
        .o_at_term  (w_tmo_term)
    );

    // Frame state machine with registered filter and sink controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_filt_enable <= 1'b0;
            r_fep         <= 1'b0;
            r_out_valid   <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_img_in      <= '0;
            r_out_data    <= '0;
        end else begin
            r_filt_enable <= 1'b0;
            r_out_valid   <= 1'b0;
            r_done        <= 1'b0;
            if (abort) begin
                r_state <= ST_IDLE;
                r_fep   <= 1'b0;
                r_error <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (start) begin
                            r_state <= ST_LOAD;
                            r_error <= 1'b0;
                        end else if (r_state == ST_DONE) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_LOAD: begin
                        if (w_hs) begin
                            r_img_in      <= in_data;
                            r_filt_enable <= 1'b1;
                            if (w_in_term) begin
                                r_state <= ST_PROCESS;
                            end
                        end
                    end
                    ST_PROCESS: begin
                        if (!r_fep) begin
                            r_fep <= 1'b1;
                        end else if (filt_finish) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_fep   <= 1'b0;
                        end else if (w_tmo_term) begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                            r_fep   <= 1'b0;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= filt_image_output;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready            = (r_state == ST_LOAD);
    assign busy                = (r_state == ST_LOAD) || (r_state == ST_PROCESS);
    assign filt_image_input    = r_img_in;
    assign filt_enable         = r_filt_enable;
    assign filt_enable_process = r_fep;
    assign out_valid           = r_out_valid;
    assign out_data            = r_out_data;
    assign done                = r_done;
    assign error               = r_error;

endmodule

// File: tb/tb_highpass_sequencer.sv
// Scoreboard bench for highpass_sequencer with a behavioural filter model.
module tb_highpass_sequencer;

    localparam int NP = 16;
    localparam int TO = 32;
    localparam int CW = $clog2(TO + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready;
    logic [7:0]    fii;
    logic          fe;
    logic          fep;
    logic [7:0]    fio = '0;
    logic          ff = 1'b0;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] pic;
    logic [CW-1:0] poc;

    int passed = 0;
    int total  = 0;
    int done_seen = 0;
    int fm_finish_after = -1;
    int fm_cnt = 0;
    logic [7:0] exp_pix[$];
    logic [7:0] exp_out[$];

    highpass_sequencer #(
        .NUM_PIXELS     (NP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .abort               (abort),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_ready            (in_ready),
        .filt_image_input    (fii),
        .filt_enable         (fe),
        .filt_enable_process (fep),
        .filt_image_output   (fio),
        .filt_finish         (ff),
        .out_valid           (out_valid),
        .out_data            (out_data),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .pix_in_count        (pic),
        .pix_out_count       (poc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Filter model: during process cycles it produces random pixels and
    // raises finish after the configured number of output cycles; every
    // pixel that should reach the sink is queued as expected output.
    always @(posedge clk) begin
        #2;
        if (fep) begin
            fm_cnt++;
            if (fm_finish_after >= 0 && fm_cnt == fm_finish_after + 1) begin
                ff = 1'b1;
            end else begin
                ff  = 1'b0;
                fio = 8'($urandom);
                if (!(fm_finish_after < 0 && fm_cnt >= TO) && !rst && !abort)
                    exp_out.push_back(fio);
            end
        end else begin
            fm_cnt = 0;
            ff     = 1'b0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a pixel.
    always @(negedge clk) begin
        if (fe) begin
            if (exp_pix.size() == 0) chk("filt_enable_unexpected", 1, 0);
            else chk("filt_image_input", fii, exp_pix.pop_front());
        end
        if (out_valid) begin
            if (exp_out.size() == 0) chk("out_valid_unexpected", 1, 0);
            else chk("out_data", out_data, exp_out.pop_front());
        end
        if (done) done_seen++;
    end

    task automatic all_zero(input string name);
        chk(name, int'(|{in_ready, fii, fe, fep, out_valid, out_data, busy, done, error, pic, poc}), 0);
    endtask

    // vmode: 0 valid held, 1 toggling, 2 random. dmode: 0 counting, 1 random.
    task automatic run_frame(input string tag, input int vmode, input int dmode,
                             input int finish_after, input int abort_at,
                             input int rst_at, input int sa_in_done);
        int acc = 0;
        int k = 0;
        int budget = 0;
        int act = 0;
        fm_finish_after = finish_after;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_in_ready_load"}, in_ready, 1);
        chk({tag, "_busy_load"}, busy, 1);
        chk({tag, "_pic_cleared"}, pic, 0);
        chk({tag, "_error_cleared"}, error, 0);
        while (acc < NP) begin
            case (vmode)
                0: in_valid = 1'b1;
                1: in_valid = (k % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = (dmode != 0) ? 8'($urandom) : 8'(acc);
            if (in_valid) exp_pix.push_back(in_data);
            step();
            if (in_valid) acc++;
            k++;
            if (abort_at > 0 && acc == abort_at) begin
                in_valid = 1'b0;
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk({tag, "_abort_in_ready"}, in_ready, 0);
                chk({tag, "_abort_filt_enable"}, fe, 0);
                chk({tag, "_abort_busy"}, busy, 0);
                chk({tag, "_abort_pic"}, pic, abort_at);
                chk({tag, "_abort_pix_q"}, exp_pix.size(), 0);
                return;
            end
        end
        in_valid = 1'b0;
        chk({tag, "_in_ready_fall"}, in_ready, 0);
        chk({tag, "_last_enable"}, fe, 1);
        chk({tag, "_fep_late"}, fep, 0);
        chk({tag, "_pic_full"}, pic, NP);
        step();
        chk({tag, "_fep_on"}, fep, 1);
        chk({tag, "_enable_off"}, fe, 0);
        while (!(done || error) && budget < 200) begin
            if (rst_at > 0 && fep) begin
                act++;
                if (act == rst_at) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    all_zero({tag, "_rst_zero"});
                    chk({tag, "_rst_out_q"}, exp_out.size(), 0);
                    return;
                end
            end
            step();
            budget++;
        end
        if (budget >= 200) begin
            chk({tag, "_wait_expired"}, 0, 1);
            return;
        end
        chk({tag, "_out_q_empty"}, exp_out.size(), 0);
        chk({tag, "_pix_q_empty"}, exp_pix.size(), 0);
        chk({tag, "_fep_end"}, fep, 0);
        if (finish_after >= 0) begin
            chk({tag, "_done"}, done, 1);
            chk({tag, "_no_error"}, error, 0);
            chk({tag, "_poc"}, poc, finish_after);
        end else begin
            chk({tag, "_error"}, error, 1);
            chk({tag, "_err_out_valid"}, out_valid, 0);
            chk({tag, "_err_poc"}, poc, TO - 1);
        end
        if (sa_in_done != 0) begin
            start = 1'b1;
            abort = 1'b1;
            step();
            start = 1'b0;
            abort = 1'b0;
            chk({tag, "_sa_in_ready"}, in_ready, 0);
            chk({tag, "_sa_busy"}, busy, 0);
            chk({tag, "_sa_done"}, done, 0);
            chk({tag, "_sa_poc_held"}, poc, finish_after);
        end else if (finish_after >= 0) begin
            step();
            chk({tag, "_done_pulse"}, done, 0);
            chk({tag, "_idle_busy"}, busy, 0);
            chk({tag, "_poc_held"}, poc, finish_after);
        end
    endtask

    initial begin
        repeat (3) step();
        all_zero("reset_zero");
        rst = 1'b0;
        step();
        run_frame("t1", 0, 0, 16, 0, 0, 0);
        chk("t1_done_count", done_seen, 1);
        run_frame("t2", 1, 1, 16, 0, 0, 0);
        run_frame("t3", 0, 1, -1, 0, 0, 0);
        run_frame("t4", 0, 1, 16, 5, 0, 0);
        run_frame("t4b", 2, 1, $urandom_range(1, 20), 0, 0, 0);
        run_frame("t5", 0, 1, 12, 0, 4, 0);
        run_frame("t5b", 0, 1, 8, 0, 0, 1);
        step();
        chk("final_busy", busy, 0);
        chk("done_count", done_seen, 4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/highpass_sequencer.md
Name: highpass_sequencer

Overview:
Frame-level controller that sequences the highpass filter through its two phases for one image: LOAD (stream NUM_PIXELS 8-bit pixels into the filter with enable high), then PROCESS (hold enable_process high and forward filter output each cycle until finish). It sits between a valid/ready pixel source and a valid-only pixel sink, replacing the file-driven stimulus with synthesizable sequencing. It adds start/abort control, pixel counting, a processing timeout and status flags.

Parameters:
NUM_PIXELS, 65536, pixels per frame loaded before switching to PROCESS (minimum 2).
TIMEOUT_CYCLES, 1048576, maximum PROCESS cycles without filt_finish before ERROR.
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the internal cycle and pixel counters (must also cover NUM_PIXELS).

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame from IDLE, DONE or ERROR; ignored otherwise
abort  in  1  return to IDLE from any state on the next edge
in_valid  in  1  source pixel valid
in_data  in  8  source pixel
in_ready  out  1  high only in LOAD
filt_image_input  out  8  registered pixel to filter image_input
filt_enable  out  1  registered; filter samples filt_image_input on each edge where this is high
filt_enable_process  out  1  registered; high throughout PROCESS
filt_image_output  in  8  filter image_output
filt_finish  in  1  filter finish
out_valid  out  1  registered; sink pixel valid (no backpressure)
out_data  out  8  registered output pixel
busy  out  1  high in LOAD or PROCESS
done  out  1  one-cycle pulse on entering DONE
error  out  1  sticky in ERROR until start, abort or rst
pix_in_count  out  CNT_W  pixels accepted this frame
pix_out_count  out  CNT_W  pixels forwarded this frame

Behaviour:
- Reset: state IDLE; all outputs 0, including counts and filt_image_input.
- States: IDLE, LOAD, PROCESS, DONE, ERROR.
- IDLE/DONE/ERROR + start: LOAD; counts cleared; error cleared.
- LOAD: in_ready=1. Each handshake (in_valid & in_ready) registers in_data into filt_image_input, sets filt_enable=1 for the next cycle and increments pix_in_count.
- LOAD with no handshake: filt_enable=0 on the next cycle and filt_image_input holds its value.
- LOAD exit: the handshake that makes pix_in_count reach NUM_PIXELS moves to PROCESS. in_ready drops the same edge, so no extra pixel is accepted.
- PROCESS: filt_enable_process=1 starting the cycle after the last filt_enable pulse; filt_enable=0.
- PROCESS, cycles with filt_finish=0: the next cycle has out_valid=1, out_data=filt_image_output; pix_out_count increments.
- PROCESS, cycle with filt_finish=1: not forwarded. Next state DONE, done=1 for one cycle, filt_enable_process=0.
- PROCESS timeout: the cycle counter increments each PROCESS cycle. When it reaches TIMEOUT_CYCLES with no finish, go to ERROR: error=1, filt_enable_process=0, out_valid=0.
- DONE: returns to IDLE after one cycle unless start is high, in which case it goes to LOAD. Counts hold until the next start.
- abort vs start: abort has priority over start in the same cycle. Abort deasserts filt_enable, filt_enable_process and out_valid on the next edge and leaves counts as they are.
- rst mid-frame: identical to the reset values above; the filter receives no partial phase signalling beyond that edge.
- start while busy: ignored.
- Latency: in handshake to filt_enable high is 1 cycle. filt_image_output sample to out_valid is 1 cycle.

Decomposition:
- Shared package hp_seq_pkg: state enum (IDLE, LOAD, PROCESS, DONE, ERROR) and the default NUM_PIXELS and TIMEOUT_CYCLES constants.
- One natural sub-module, hp_seq_counter: a loadable up-counter with clear, enable and terminal-compare. It is instantiated three times (pixel-in, pixel-out, timeout).

Test Plan:
1. NUM_PIXELS=16, in_valid held high with in_data=0..15, filter model asserts finish after 16 output cycles -> filt_enable high for exactly 16 consecutive cycles carrying 0..15; 16 out_valid pulses; pix_in_count=16, pix_out_count=16; done pulses once.
2. Same frame with in_valid toggling every other cycle -> filt_enable pulses only after handshakes; no duplicate or dropped pixel; in_ready falls the edge after the 16th accept.
3. Filter model never asserts finish, TIMEOUT_CYCLES=32 -> ERROR after 32 PROCESS cycles; error=1, filt_enable_process=0; a later start clears error and enters LOAD.
4. abort asserted after 5 pixels in LOAD -> IDLE next edge; in_ready=0, filt_enable=0, pix_in_count=5; a subsequent start reloads and counts from 0.
5. rst pulsed during PROCESS, plus start and abort asserted together in DONE -> all outputs 0 after the rst edge; abort wins, so the state is IDLE, not LOAD.
